// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern modes, bounce direction
// and the per-mode initial pattern.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT_UP   = 2'd0,
    MODE_COUNT_DOWN = 2'd1,
    MODE_BOUNCE     = 2'd2,
    MODE_ROTATE     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned MaxWidth = 32;

  // Result is MaxWidth wide; callers truncate to their own Width.
  function automatic logic [MaxWidth-1:0] mode_init(input mode_e m, input int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    unique case (m)
      MODE_COUNT_UP:   v = '0;
      MODE_COUNT_DOWN: v = {MaxWidth{1'b1}} >> (MaxWidth - width);
      MODE_BOUNCE:     v = MaxWidth'(1);
      MODE_ROTATE:     v = MaxWidth'(1);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Free-running step prescaler: counts 0..TickDiv-1 while en, holds otherwise.
// tick is combinational, high during the last count of each period while en.
module tick_prescaler #(
  parameter int unsigned TickDiv = 12000000
) (
  input  logic clk,
  input  logic rstx,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == CntLast);
  assign tick    = en & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator (count up/down, bounce, rotate) with pause/step.
// Optional breathing PWM overlay enabled by defining LED_PATTERN_BREATHE_EN.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned Width     = 8,
  parameter int unsigned TickDiv   = 12000000,
  parameter bit          ActiveLow = 1'b1
) (
  input  logic             clk,
  input  logic             rstx,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic             step,
  output logic             tick,
  output logic [Width-1:0] ledx
);

  localparam logic [Width-1:0] LedOff = {Width{ActiveLow}};

  logic raw_tick;
  logic adv;

  tick_prescaler #(.TickDiv(TickDiv)) u_prescaler (
    .clk  (clk),
    .rstx (rstx),
    .en   (run),
    .tick (raw_tick)
  );

  assign adv = (run & raw_tick) | (~run & step);

  mode_e            mode_in;
  mode_e            mode_q,    mode_d;
  dir_e             dir_q,     dir_d;
  logic [Width-1:0] pattern_q, pattern_d;
  logic             tick_q,    tick_d;
  logic [Width-1:0] ledx_q,    ledx_d;
  logic [Width-1:0] lit_mask;

  assign mode_in = mode_e'(mode);

  // A mode change is applied on an advance event and consumes it: the pattern
  // restarts from the new mode's initial value instead of stepping.
  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    pattern_d = pattern_q;
    if (adv) begin
      if (mode_in != mode_q) begin
        mode_d    = mode_in;
        pattern_d = Width'(mode_init(mode_in, Width));
        dir_d     = DIR_UP;
      end else begin
        unique case (mode_q)
          MODE_COUNT_UP:   pattern_d = pattern_q + Width'(1);
          MODE_COUNT_DOWN: pattern_d = pattern_q - Width'(1);
          MODE_ROTATE:     pattern_d = {pattern_q[Width-2:0], pattern_q[Width-1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              pattern_d = pattern_q << 1;
              if (pattern_d[Width-1]) dir_d = DIR_DOWN;
            end else begin
              pattern_d = pattern_q >> 1;
              if (pattern_d[0]) dir_d = DIR_UP;
            end
          end
        endcase
      end
    end
  end

`ifdef LED_PATTERN_BREATHE_EN
  logic [7:0] pwm_q,     pwm_d;
  logic [7:0] duty_q,    duty_d;
  logic       duty_up_q, duty_up_d;

  // Duty walks a 0..255..0 triangle, one step per PWM period.
  always_comb begin
    pwm_d     = pwm_q + 8'd1;
    duty_d    = duty_q;
    duty_up_d = duty_up_q;
    if (pwm_q == 8'hFF) begin
      if (duty_up_q) begin
        duty_d = duty_q + 8'd1;
        if (duty_q == 8'hFE) duty_up_d = 1'b0;
      end else begin
        duty_d = duty_q - 8'd1;
        if (duty_q == 8'h01) duty_up_d = 1'b1;
      end
    end
    lit_mask = {Width{pwm_q < duty_q}};
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      pwm_q     <= '0;
      duty_q    <= '0;
      duty_up_q <= 1'b1;
    end else begin
      pwm_q     <= pwm_d;
      duty_q    <= duty_d;
      duty_up_q <= duty_up_d;
    end
  end
`else
  assign lit_mask = {Width{1'b1}};
`endif

  // Drive is built from the next pattern so ledx changes together with tick.
  assign tick_d = adv;
  assign ledx_d = (pattern_d & lit_mask) ^ LedOff;

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      mode_q    <= MODE_COUNT_UP;
      dir_q     <= DIR_UP;
      pattern_q <= '0;
      tick_q    <= 1'b0;
      ledx_q    <= LedOff;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      tick_q    <= tick_d;
      ledx_q    <= ledx_d;
    end
  end

  assign tick = tick_q;
  assign ledx = ledx_q;

endmodule
